conv_window_gen: RTL and testbench



---
 rtl/pe_conv_pkg.sv | 27 ++
 rtl/conv_col_shift.sv | 27 ++
 rtl/conv_window_gen.sv | 115 +++++++++++
 tb/tb_conv_window_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pe_conv_pkg.sv
// Shared constants, FSM encoding and tap indexing for the conv pre-data / window / PE stages.
package pe_conv_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PAD_ROWS = 26;
    localparam int unsigned PAD_COLS = 34;
    localparam int unsigned K        = 3;
    localparam int unsigned WIN_ROWS = PAD_ROWS - 2;
    localparam int unsigned WIN_COLS = PAD_COLS - 2;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned WCOL_W   = 5;
    localparam int unsigned COL_W    = PAD_ROWS * DATA_W;
    localparam int unsigned WIN_W    = WIN_ROWS * K * K * DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } win_state_e;

    // Flat tap slot of (window row r, kernel row kr, kernel column kc) inside win_data.
    function automatic int unsigned tap_idx(input int unsigned r, input int unsigned kr,
                                            input int unsigned kc);
        return (r * K * K) + (kr * K) + kc;
    endfunction

endpackage

// File: rtl/conv_col_shift.sv
// K-deep column shift register: c0 oldest, c2 newest; shifts on en.
module conv_col_shift
    import pe_conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] c0,
    output logic [COL_W-1:0] c1,
    output logic [COL_W-1:0] c2
);

    // Column history, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            c0 <= '0;
            c1 <= '0;
            c2 <= '0;
        end else if (en) begin
            c0 <= c1;
            c1 <= c2;
            c2 <= col_in;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 window generator: holds the last three padded columns and presents all 24 vertical
// windows once per accepted column from column 2 onward.
// Option: CONV_WIN_STRIDE2_EN -> only even window columns are announced (16 per frame).
module conv_window_gen
    import pe_conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              col_vld,
    input  logic              col_sof,
    input  logic [COL_W-1:0]  col_data,
    output logic              win_vld,
    output logic [WCOL_W-1:0] win_col,
    output logic [WIN_W-1:0]  win_data,
    output logic              frame_done,
    output logic              frame_err
);

    win_state_e        state_q, state_d;
    logic [CNT_W-1:0]  col_cnt, cnt_d;
    logic              emit_d, done_d, err_d;
    logic [WCOL_W-1:0] win_col_d;
    logic [COL_W-1:0]  c0, c1, c2;
    logic [COL_W-1:0]  cols [K];

    conv_col_shift u_shift (
        .clk    (clk),
        .rst    (rst),
        .en     (col_vld),
        .col_in (col_data),
        .c0     (c0),
        .c1     (c1),
        .c2     (c2)
    );

    assign cols[0] = c0;
    assign cols[1] = c1;
    assign cols[2] = c2;

    // Window taps wired straight from the column registers (valid alongside win_vld).
    for (genvar r = 0; r < WIN_ROWS; r++) begin : g_row
        for (genvar kr = 0; kr < K; kr++) begin : g_kr
            for (genvar kc = 0; kc < K; kc++) begin : g_kc
                assign win_data[tap_idx(r, kr, kc)*DATA_W +: DATA_W] =
                    cols[kc][(PAD_ROWS-1-r-kr)*DATA_W +: DATA_W];
            end
        end
    end

    // Next state, column count and output strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = col_cnt;
        emit_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef CONV_WIN_STRIDE2_EN
        win_col_d = WCOL_W'((col_cnt - CNT_W'(2)) >> 1);
`else
        win_col_d = WCOL_W'(col_cnt - CNT_W'(2));
`endif
        if (col_vld) begin
            if (col_sof && (col_cnt != '0)) begin
                // Restart: this column becomes column 0 of a fresh frame.
                err_d   = 1'b1;
                cnt_d   = CNT_W'(1);
                state_d = PRIME;
            end else begin
                cnt_d = (col_cnt == CNT_W'(PAD_COLS-1)) ? '0 : CNT_W'(col_cnt + 1'b1);
                case (state_q)
                    IDLE:   state_d = PRIME;
                    PRIME:  if (col_cnt == CNT_W'(1)) state_d = STREAM;
                    STREAM: begin
`ifdef CONV_WIN_STRIDE2_EN
                        emit_d = ~col_cnt[0];
                        done_d = (col_cnt == CNT_W'(PAD_COLS-2));
`else
                        emit_d = 1'b1;
                        done_d = (col_cnt == CNT_W'(PAD_COLS-1));
`endif
                        if (col_cnt == CNT_W'(PAD_COLS-1)) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State and column counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_cnt <= '0;
        end else begin
            state_q <= state_d;
            col_cnt <= cnt_d;
        end
    end

    // Registered strobes and window column index.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_vld    <= 1'b0;
            win_col    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            win_vld    <= emit_d;
            frame_done <= done_d;
            frame_err  <= err_d;
            if (emit_d) win_col <= win_col_d;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: reset, ramp, paced, mid-frame sof, back-to-back frames.
// Build with +define+CONV_WIN_STRIDE2_EN for the stride-2 expectations.
module tb_conv_window_gen;
    import pe_conv_pkg::*;

`ifdef CONV_WIN_STRIDE2_EN
    localparam bit S2 = 1'b1;
`else
    localparam bit S2 = 1'b0;
`endif
    localparam int FRAME_WINS = S2 ? 16 : 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              col_vld;
    logic              col_sof;
    logic [COL_W-1:0]  col_data;
    logic              win_vld;
    logic [WCOL_W-1:0] win_col;
    logic [WIN_W-1:0]  win_data;
    logic              frame_done;
    logic              frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    conv_window_gen dut (
        .clk        (clk),
        .rst        (rst),
        .col_vld    (col_vld),
        .col_sof    (col_sof),
        .col_data   (col_data),
        .win_vld    (win_vld),
        .win_col    (win_col),
        .win_data   (win_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ramp column: pixel(r,c) = r + c + off.
    function automatic logic [COL_W-1:0] ramp_col(input int c, input int off);
        logic [COL_W-1:0] v;
        v = '0;
        for (int r = 0; r < PAD_ROWS; r++) v[(PAD_ROWS-1-r)*DATA_W +: DATA_W] = 8'(r + c + off);
        return v;
    endfunction

    // Expected 9 taps of window row r whose oldest column is input column b.
    function automatic logic [71:0] exp_row(input int b, input int r, input int off);
        logic [71:0] v;
        v = '0;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
                v[(kr*3+kc)*8 +: 8] = 8'(r + kr + b + kc + off);
        return v;
    endfunction

    task automatic step(input logic vld, input logic sof, input logic [COL_W-1:0] d,
                        input logic e_vld, input int e_wcol, input logic e_done,
                        input logic e_err, input int e_base, input int e_off, input string tag);
        col_vld  = vld;
        col_sof  = sof;
        col_data = d;
        @(posedge clk);
        #1;
        if (win_vld) pulses++;
        check({tag, "_vld"},  72'(win_vld),    72'(e_vld));
        check({tag, "_done"}, 72'(frame_done), 72'(e_done));
        check({tag, "_err"},  72'(frame_err),  72'(e_err));
        if (e_vld) begin
            check({tag, "_wcol"}, 72'(win_col), 72'(e_wcol));
            for (int r = 0; r < WIN_ROWS; r++)
                check($sformatf("%s_row%0d", tag, r), win_data[r*72 +: 72], exp_row(e_base, r, e_off));
        end
        col_vld = 1'b0;
        col_sof = 1'b0;
    endtask

    // Feed ramp columns first..last of a frame, gap idle cycles after each column.
    task automatic run_cols(input int first, input int last, input int off, input int gap,
                            input logic err_first, input string t);
        for (int k = first; k <= last; k++) begin
            int  w;
            logic ev, ed;
            w  = k - 2;
            ev = (k >= 2) && (!S2 || (w % 2 == 0));
            ed = S2 ? (k == PAD_COLS-2) : (k == PAD_COLS-1);
            step(1'b1, k == 0, ramp_col(k, off), ev, S2 ? w / 2 : w, ed,
                 (k == first) && err_first, w, off, $sformatf("%s_k%0d", t, k));
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0, 0, 0, $sformatf("%s_k%0d_idle", t, k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        col_vld  = 1'b0;
        col_sof  = 1'b0;
        col_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset in the middle of a frame
        run_cols(0, 15, 0, 0, 1'b0, "t1a");
        rst     = 1'b1;
        col_vld = 1'b1;
        col_data = ramp_col(16, 0);
        repeat (2) @(posedge clk);
        #1;
        col_vld = 1'b0;
        check("t1_rst_vld",  72'(win_vld),    72'(0));
        check("t1_rst_wcol", 72'(win_col),    72'(0));
        check("t1_rst_done", 72'(frame_done), 72'(0));
        check("t1_rst_err",  72'(frame_err),  72'(0));
        for (int r = 0; r < WIN_ROWS; r++)
            check($sformatf("t1_rst_row%0d", r), win_data[r*72 +: 72], 72'(0));
        rst    = 1'b0;
        pulses = 0;
        run_cols(0, 33, 0, 0, 1'b0, "t1b");
        check("t1_pulses", 72'(pulses), 72'(FRAME_WINS));

        // 2/6: ramp frame, explicit first-window row 0
        pulses = 0;
        run_cols(0, 2, 0, 0, 1'b0, "t2");
        check("t2_first_row0", win_data[71:0], 72'h04_03_02_03_02_01_02_01_00);
        run_cols(3, 33, 0, 0, 1'b0, "t2");
        check("t2_pulses", 72'(pulses), 72'(FRAME_WINS));

        // 3: paced input, one column in 24 cycles
        pulses = 0;
        run_cols(0, 33, 0, 23, 1'b0, "t3");
        check("t3_pulses", 72'(pulses), 72'(FRAME_WINS));

        // 4: sof at column 10 restarts; sof without vld ignored
        pulses = 0;
        run_cols(0, 9, 0, 0, 1'b0, "t4a");
        step(1'b0, 1'b1, ramp_col(5, 0), 1'b0, 0, 1'b0, 1'b0, 0, 0, "t4_sof_novld");
        run_cols(0, 33, 50, 0, 1'b1, "t4b");
        check("t4_pulses", 72'(pulses), 72'(S2 ? 20 : 40));

        // 5: back-to-back frames
        pulses = 0;
        run_cols(0, 33, 0, 0, 1'b0, "t5a");
        run_cols(0, 33, 100, 0, 1'b0, "t5b");
        check("t5_pulses", 72'(pulses), 72'(2 * FRAME_WINS));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
